bit_serial_operand_serializer: RTL and testbench

//  Transmit end of the bit-serial multiplier interface. Accepts parallel W-bit

---
 rtl/bit_serial_operand_serializer.sv | 154 +++++++++++++++
 tb/tb_bit_serial_operand_serializer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_operand_serializer.sv
// Serial operand source for the bit-serial multiplier array: X, Y, X&Y, frame token.
// Define BSM_SERIALIZER_SIGNED_EN to sign-extend during flush (two's complement operands).
module bit_serial_operand_serializer #(
    parameter int W     = 8,
    parameter int CNT_W = $clog2(2*W)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    output logic         x,
    output logic         y,
    output logic         xy,
    output logic         r,
    output logic         last_bit,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(W-1);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(2*W-1);

    state_t           r_state;
    state_t           w_nxt_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [W-1:0]     r_sx;
    logic [W-1:0]     r_sy;
    logic [W-1:0]     w_nxt_sx;
    logic [W-1:0]     w_nxt_sy;
    logic             w_fill_x;
    logic             w_fill_y;
    logic             w_final;
    logic             w_xfer;

    logic r_x;
    logic r_y;
    logic r_xy;
    logic r_r;
    logic r_last;
    logic r_busy;
    logic w_x_n;
    logic w_y_n;
    logic w_xy_n;
    logic w_r_n;
    logic w_last_n;
    logic w_busy_n;

    // Shifting continues through flush, so the fill bit alone decides zero vs sign extension.
`ifdef BSM_SERIALIZER_SIGNED_EN
    assign w_fill_x = r_sx[W-1];
    assign w_fill_y = r_sy[W-1];
`else
    assign w_fill_x = 1'b0;
    assign w_fill_y = 1'b0;
`endif

    assign w_final  = (r_state == S_FLUSH) && (r_cnt == LAST_BIT);
    assign in_ready = reset_n && ((r_state == S_IDLE) || w_final);
    assign w_xfer   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
            r_x     <= 1'b0;
            r_y     <= 1'b0;
            r_xy    <= 1'b0;
            r_r     <= 1'b0;
            r_last  <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_sx    <= w_nxt_sx;
            r_sy    <= w_nxt_sy;
            r_x     <= w_x_n;
            r_y     <= w_y_n;
            r_xy    <= w_xy_n;
            r_r     <= w_r_n;
            r_last  <= w_last_n;
            r_busy  <= w_busy_n;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_sx    = {w_fill_x, r_sx[W-1:1]};
        w_nxt_sy    = {w_fill_y, r_sy[W-1:1]};
        unique case (r_state)
            S_IDLE: begin
                w_nxt_state = S_IDLE;
            end
            S_SHIFT: begin
                w_nxt_cnt = r_cnt + 1'b1;
                if (r_cnt == LAST_SHIFT) begin
                    w_nxt_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_final) begin
                    w_nxt_state = S_IDLE;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
        if (w_xfer) begin
            w_nxt_state = S_SHIFT;
            w_nxt_cnt   = '0;
            w_nxt_sx    = in_x;
            w_nxt_sy    = in_y;
        end
    end

    // Outputs are decoded from the next state so they land registered with it.
    always_comb begin
        w_x_n    = 1'b0;
        w_y_n    = 1'b0;
        w_xy_n   = 1'b0;
        w_r_n    = 1'b0;
        w_last_n = 1'b0;
        w_busy_n = 1'b0;
        if (w_nxt_state != S_IDLE) begin
            w_x_n    = w_nxt_sx[0];
            w_y_n    = w_nxt_sy[0];
            w_xy_n   = w_nxt_sx[0] & w_nxt_sy[0];
            w_busy_n = 1'b1;
            w_r_n    = (w_nxt_state == S_SHIFT) && (w_nxt_cnt == '0);
            w_last_n = (w_nxt_state == S_FLUSH) && (w_nxt_cnt == LAST_BIT);
        end
    end

    assign x        = r_x;
    assign y        = r_y;
    assign xy       = r_xy;
    assign r        = r_r;
    assign last_bit = r_last;
    assign busy     = r_busy;

endmodule

// File: tb/tb_bit_serial_operand_serializer.sv
// Scoreboard bench for bit_serial_operand_serializer with a frame-level reference model.
module tb_bit_serial_operand_serializer;

    localparam int W = 8;

    typedef struct packed {
        logic x;
        logic y;
        logic xy;
        logic r;
        logic last;
    } beat_t;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         x;
    logic         y;
    logic         xy;
    logic         r;
    logic         last_bit;
    logic         busy;

    beat_t q[$];
    int    total;
    int    bad;
    bit    m_ready;
    bit    exp_rst;
    bit    acc;

    bit_serial_operand_serializer #(.W(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .x        (x),
        .y        (y),
        .xy       (xy),
        .r        (r),
        .last_bit (last_bit),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A frame is the 2W-bit extension of each operand sent LSB first.
    function automatic void push_frame(logic [W-1:0] a, logic [W-1:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        beat_t       bt;
`ifdef BSM_SERIALIZER_SIGNED_EN
        ea = {{(64-W){a[W-1]}}, a};
        eb = {{(64-W){b[W-1]}}, b};
`else
        ea = {{(64-W){1'b0}}, a};
        eb = {{(64-W){1'b0}}, b};
`endif
        for (int i = 0; i < 2*W; i++) begin
            bt.x    = ea[i];
            bt.y    = eb[i];
            bt.xy   = ea[i] & eb[i];
            bt.r    = (i == 0);
            bt.last = (i == 2*W-1);
            q.push_back(bt);
        end
    endfunction

    initial begin
        total   = 0;
        bad     = 0;
        m_ready = 1'b0;
        exp_rst = 1'b1;
        acc     = 1'b0;
    end

    // Model handshake: acceptance decided by the model's own ready.
    always @(posedge clk) begin
        if (!reset_n) begin
            q.delete();
            exp_rst = 1'b1;
            acc     = 1'b0;
        end else begin
            exp_rst = 1'b0;
            acc     = m_ready && in_valid;
            if (acc) push_frame(in_x, in_y);
        end
    end

    always @(negedge clk) begin
        logic [6:0] want;
        logic [6:0] got;
        beat_t      bt;
        if (exp_rst) begin
            want    = 7'b0000100;
            m_ready = 1'b1;
        end else if (q.size() > 0) begin
            bt      = q.pop_front();
            want    = {bt.x, bt.y, bt.xy, bt.r, bt.last, 1'b1, 1'b0};
            m_ready = bt.last;
        end else begin
            want    = 7'b0;
            m_ready = 1'b1;
        end
        want[0] = reset_n && m_ready;
        got     = {x, y, xy, r, last_bit, busy, in_ready};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL outputs t=%0t {x,y,xy,r,last,busy,rdy} got=%b want=%b",
                     $time, got, want);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_acc();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            step();
            if (acc) ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout t=%0t got=none want=transfer", $time);
        end
    endtask

    task automatic send(logic [W-1:0] a, logic [W-1:0] b);
        in_valid = 1'b1;
        in_x     = a;
        in_y     = b;
        wait_acc();
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (2) step();

        send(8'h05, 8'h03);
        repeat (20) step();

        in_valid = 1'b1;
        in_x     = 8'hFF;
        in_y     = 8'hFF;
        wait_acc();
        in_x = 8'h01;
        in_y = 8'h80;
        wait_acc();
        in_valid = 1'b0;
        repeat (40) step();

        send(8'hFB, 8'h02);
        repeat (20) step();

        send(8'hA5, 8'h3C);
        repeat (6) step();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (3) step();

        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_x     = W'($urandom);
            in_y     = W'($urandom);
            reset_n  = ($urandom_range(0, 299) != 0);
            step();
        end

        reset_n  = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 4*W && q.size() != 0; k++) step();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0 beats pending", q.size());
        end
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
